// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// bus_pkg : shared types and default address map for the bus fabric
// Rev 1.0
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } fab_state_t;

    localparam logic [15:0] DEFAULT_RDATA = 16'hf345;

    localparam logic [11:0] RAM_BASE     = 12'h000;
    localparam logic [11:0] RAM_MASK     = 12'he00;
    localparam logic [11:0] BUTTONDATA   = 12'h900;
    localparam logic [11:0] BUTTONCHOICE = 12'h901;
    localparam logic [11:0] SEVENSEG     = 12'hb00;
    localparam logic [11:0] FULL_MASK    = 12'hfff;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hff) ? val : val + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addr_decode.sv
`default_nettype none
// ============================================================================
// addr_decode : base/mask slave decode, lowest index wins on overlap
// Rev 1.0
// ============================================================================
module addr_decode #(
    parameter int              NSLV     = 4,
    parameter int              AW       = 12,
    parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0]   addr,
    output logic [NSLV-1:0] sel,
    output logic            hit
);

    logic [NSLV-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_match
            assign match[gi] = ((addr & SLV_MASK[gi*AW +: AW]) == SLV_BASE[gi*AW +: AW]);
        end
    endgenerate

    // Walk from the top so the lowest matching index is the last to overwrite.
    always_comb begin
        sel = '0;
        for (int j = NSLV - 1; j >= 0; j--) begin
            if (match[j]) begin
                sel    = '0;
                sel[j] = 1'b1;
            end
        end
    end

    assign hit = |match;

endmodule
`default_nettype wire

// File: rtl/bus_fabric.sv
`default_nettype none
// ============================================================================
// bus_fabric : single-master memory-mapped interconnect with wait states,
//              access timeout, error flag and saturating error counter
// Rev 1.0
// ============================================================================
module bus_fabric
    import bus_pkg::*;
#(
    parameter int                 DW            = 16,
    parameter int                 AW            = 12,
    parameter int                 NSLV          = 4,
    parameter logic [NSLV*AW-1:0] SLV_BASE      = {SEVENSEG, BUTTONCHOICE, BUTTONDATA, RAM_BASE},
    parameter logic [NSLV*AW-1:0] SLV_MASK      = {FULL_MASK, FULL_MASK, FULL_MASK, RAM_MASK},
    parameter int                 TIMEOUT       = 15,
    parameter logic [DW-1:0]      DEFAULT_RDATA = DW'(bus_pkg::DEFAULT_RDATA)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m_req,
    input  logic               m_we,
    input  logic [AW-1:0]      m_addr,
    input  logic [DW-1:0]      m_wdata,
    output logic [DW-1:0]      m_rdata,
    output logic               m_ready,
    output logic               m_err,
    output logic [7:0]         err_cnt,
    output logic [NSLV-1:0]    s_sel,
    output logic               s_we,
    output logic [AW-1:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    input  logic [NSLV*DW-1:0] s_rdata,
    input  logic [NSLV-1:0]    s_ack
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    fab_state_t      state;
    logic [7:0]      cnt;
    logic [NSLV-1:0] dec_sel;
    logic            dec_hit;
    logic            ack_sel;
    logic [DW-1:0]   sel_rdata;

    addr_decode #(
        .NSLV     (NSLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr (m_addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // Only the currently selected slave may complete or drive read data.
    assign ack_sel = |(s_ack & s_sel);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (s_sel[i]) begin
                sel_rdata = s_rdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            s_sel   <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_rdata <= '0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            err_cnt <= '0;
        end else begin
            m_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_req) begin
                        s_we    <= m_we;
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        cnt     <= '0;
                        if (dec_hit) begin
                            s_sel <= dec_sel;
                            state <= ACCESS;
                        end else begin
                            m_err   <= 1'b1;
                            m_rdata <= DEFAULT_RDATA;
                            m_ready <= 1'b1;
                            err_cnt <= sat_inc8(err_cnt);
                            state   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (ack_sel) begin
                        if (!s_we) begin
                            m_rdata <= sel_rdata;
                        end
                        m_err   <= 1'b0;
                        m_ready <= 1'b1;
                        s_sel   <= '0;
                        state   <= RESP;
                    end else if (cnt == TO_LAST) begin
                        m_err   <= 1'b1;
                        m_rdata <= DEFAULT_RDATA;
                        m_ready <= 1'b1;
                        err_cnt <= sat_inc8(err_cnt);
                        s_sel   <= '0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_fabric.sv
`default_nettype none
// ============================================================================
// tb_bus_fabric : randomized scoreboard bench for bus_fabric
// Rev 1.0
// ============================================================================
module tb_bus_fabric;

    localparam int DW      = 16;
    localparam int AW      = 12;
    localparam int NSLV    = 4;
    localparam int TIMEOUT = 15;
    localparam logic [15:0] DEF = 16'hf345;

    logic               clk;
    logic               rst_n;
    logic               m_req;
    logic               m_we;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_wdata;
    logic [DW-1:0]      m_rdata;
    logic               m_ready;
    logic               m_err;
    logic [7:0]         err_cnt;
    logic [NSLV-1:0]    s_sel;
    logic               s_we;
    logic [AW-1:0]      s_addr;
    logic [DW-1:0]      s_wdata;
    logic [NSLV*DW-1:0] s_rdata;
    logic [NSLV-1:0]    s_ack;

    bus_fabric #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .err_cnt (err_cnt),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic [7:0]  cnt;
        int          start;
        int          lat;
    } exp_t;

    exp_t q[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    logic [11:0] win_base [4] = '{12'h000, 12'h900, 12'h901, 12'hb00};
    logic [11:0] win_mask [4] = '{12'he00, 12'hfff, 12'hfff, 12'hfff};

    int          cur_wait  = 0;
    logic [15:0] cur_data  = '0;
    bit          cur_spur  = 0;
    bit          busy      = 0;
    logic [3:0]  exp_sel   = '0;
    logic        exp_we    = 1'b0;
    logic [11:0] exp_addr  = '0;
    logic [15:0] exp_wdata = '0;
    int          model_err = 0;
    logic [15:0] last_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int model_target(input logic [11:0] addr);
        for (int i = 0; i < 4; i++)
            if ((addr & win_mask[i]) == win_base[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) cyc++;

    // Slave model: ack after cur_wait wait cycles, optional stray ack elsewhere.
    int  k     = 0;
    bit  inacc = 0;
    always @(posedge clk) begin
        #2;
        if (s_sel != '0) begin
            if (!inacc) begin
                inacc = 1;
                k = 0;
            end else begin
                k++;
            end
            s_ack = (k == cur_wait) ? s_sel : 4'b0000;
            if (cur_spur) s_ack = s_ack | {s_sel[1:0], s_sel[3:2]};
            s_rdata = {$urandom, $urandom};
            for (int i = 0; i < NSLV; i++)
                if (s_sel[i]) s_rdata[i*DW +: DW] = cur_data;
        end else begin
            inacc = 0;
            s_ack = '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_ready", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("m_rdata", m_rdata, e.rdata);
                chk("m_err", m_err, e.err);
                chk("err_cnt", err_cnt, e.cnt);
                chk("latency", cyc - e.start + 1, e.lat);
            end
        end
        if (busy && s_sel != '0)
            chk("s_bus", {s_sel, s_we, s_addr, s_wdata}, {exp_sel, exp_we, exp_addr, exp_wdata});
        if (busy && exp_sel == '0)
            chk("no_sel", s_sel, 0);
    end

    task automatic do_access(input bit we, input logic [11:0] addr, input logic [15:0] wdata,
                             input int waitc, input bit spur);
        exp_t e;
        int   tgt;
        bit   done;
        tgt       = model_target(addr);
        cur_wait  = waitc;
        cur_data  = 16'($urandom);
        cur_spur  = spur;
        exp_sel   = (tgt >= 0) ? (4'b0001 << tgt) : 4'b0000;
        exp_we    = we;
        exp_addr  = addr;
        exp_wdata = wdata;
        if (tgt < 0) begin
            e.err = 1'b1; e.rdata = DEF; e.lat = 2;
        end else if (waitc >= TIMEOUT) begin
            e.err = 1'b1; e.rdata = DEF; e.lat = TIMEOUT + 2;
        end else begin
            e.err = 1'b0; e.rdata = we ? last_rdata : cur_data; e.lat = 3 + waitc;
        end
        if (e.err) model_err = (model_err < 255) ? model_err + 1 : 255;
        e.cnt      = 8'(model_err);
        last_rdata = e.rdata;
        e.start    = cyc;
        q.push_back(e);
        m_we = we; m_addr = addr; m_wdata = wdata; m_req = 1'b1; busy = 1;
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk); #1;
            if (m_ready) done = 1;
        end
        m_req = 1'b0;
        @(negedge clk);
        busy = 0;
        if (!done) begin
            chk("ready_timeout", 0, 1);
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        s_ack = '0; s_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {s_sel, m_ready, m_err, m_rdata, s_we, s_addr, s_wdata, err_cnt}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_access(0, 12'h005, 16'h0000, 0, 0);
        do_access(1, 12'hb00, 16'h00ab, 4, 0);
        do_access(0, 12'h700, 16'h0000, 0, 0);
        do_access(0, 12'h900, 16'h0000, 99, 0);
        do_access(0, 12'h900, 16'h0000, TIMEOUT - 1, 0);
        do_access(0, 12'h010, 16'h0000, 5, 1);
        do_access(1, 12'h901, 16'h5a5a, 2, 1);

        for (int it = 0; it < 150; it++) begin
            logic [11:0] a;
            int          w;
            case ($urandom_range(0, 4))
                0: a = {3'b000, 9'($urandom)};
                1: a = 12'h900;
                2: a = 12'h901;
                3: a = 12'hb00;
                default: a = 12'($urandom);
            endcase
            w = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 5);
            do_access(1'($urandom), a, 16'($urandom), w, ($urandom_range(0, 3) == 0));
        end

        for (int it = 0; it < 260; it++)
            do_access(1'($urandom), 12'h700, 16'($urandom), 0, 0);
        chk("err_cnt_saturated", err_cnt, 255);

        cur_wait = 100; cur_spur = 0;
        m_we = 1'b0; m_addr = 12'h901; m_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sel_before_reset", s_sel, 4'b0100);
        rst_n = 1'b0; m_req = 1'b0;
        #1;
        chk("reset_mid_access", {s_sel, m_ready, err_cnt}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("no_ready_in_reset", m_ready, 0);
        rst_n = 1'b1;
        model_err = 0; last_rdata = '0;
        @(posedge clk); #1;
        do_access(0, 12'h300, 16'h0000, 0, 0);
        do_access(0, 12'h1ff, 16'h0000, 1, 0);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
